// File: rtl/pixel_array_sequencer_if.sv
// Control, duration and readout-handshake bundle between the frame sequencer and its controller.
// The master modport drives commands and rd_ready. The slave modport (the sequencer) drives phases and addresses.
interface pixel_array_sequencer_if #(
    parameter int ROWS    = 2,
    parameter int COLS    = 2,
    parameter int CNT_W   = 16,
    parameter int FRAME_W = 8
);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    logic               start;
    logic               continuous;
    logic [CNT_W-1:0]   t_erase;
    logic [CNT_W-1:0]   t_expose;
    logic [CNT_W-1:0]   t_convert;
    logic               rd_ready;
`ifdef PIXSEQ_ABORT_EN
    logic               abort;
`endif
    logic               erase;
    logic               expose;
    logic               convert;
    logic               read;
    logic               rd_valid;
    logic [ROW_W-1:0]   row_addr;
    logic [COL_W-1:0]   col_addr;
    logic               busy;
    logic               frame_done;
    logic [FRAME_W-1:0] frame_cnt;

    modport master (
`ifdef PIXSEQ_ABORT_EN
        output abort,
`endif
        output start, continuous, t_erase, t_expose, t_convert, rd_ready,
        input  erase, expose, convert, read, rd_valid, row_addr, col_addr,
        input  busy, frame_done, frame_cnt
    );

    modport slave (
`ifdef PIXSEQ_ABORT_EN
        input  abort,
`endif
        input  start, continuous, t_erase, t_expose, t_convert, rd_ready,
        output erase, expose, convert, read, rd_valid, row_addr, col_addr,
        output busy, frame_done, frame_cnt
    );
endinterface

// File: rtl/pixel_array_sequencer.sv
// Frame sequencer for the pixel array: erase/expose/convert/read phases. Optional abort input under PIXSEQ_ABORT_EN.
// Latency: all outputs come from registers; phase lengths are max(t,1) cycles; READ takes ROWS*COLS cycles plus stalls.
// Backpressure: rd_ready low holds row/col with rd_valid high; the earlier phases are never stalled.
module pixel_array_sequencer #(
    parameter int ROWS    = 2,
    parameter int COLS    = 2,
    parameter int CNT_W   = 16,
    parameter int FRAME_W = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    pixel_array_sequencer_if.slave bus
);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_READ} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   sh_erase_q, sh_erase_d;
    logic [CNT_W-1:0]   sh_expose_q, sh_expose_d;
    logic [CNT_W-1:0]   sh_convert_q, sh_convert_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic               done_q, done_d;
    logic [FRAME_W-1:0] fcnt_q, fcnt_d;
    logic               abort_req;
    logic               last_pix;

`ifdef PIXSEQ_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    // A zero duration still occupies the phase for one cycle.
    function automatic logic phase_end(input logic [CNT_W-1:0] cnt, input logic [CNT_W-1:0] dur);
        return (dur == '0) || (cnt == dur - CNT_W'(1));
    endfunction

    assign last_pix = (row_q == ROW_W'(ROWS - 1)) && (col_q == COL_W'(COLS - 1));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sh_erase_d   = sh_erase_q;
        sh_expose_d  = sh_expose_q;
        sh_convert_d = sh_convert_q;
        row_d        = row_q;
        col_d        = col_q;
        done_d       = 1'b0;
        fcnt_d       = fcnt_q;

        if (abort_req && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            row_d   = '0;
            col_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start && !abort_req) begin
                        sh_erase_d   = bus.t_erase;
                        sh_expose_d  = bus.t_expose;
                        sh_convert_d = bus.t_convert;
                        cnt_d        = '0;
                        state_d      = S_ERASE;
                    end
                end
                S_ERASE: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (phase_end(cnt_q, sh_erase_q)) begin
                        cnt_d   = '0;
                        state_d = S_EXPOSE;
                    end
                end
                S_EXPOSE: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (phase_end(cnt_q, sh_expose_q)) begin
                        cnt_d   = '0;
                        state_d = S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (phase_end(cnt_q, sh_convert_q)) begin
                        cnt_d   = '0;
                        row_d   = '0;
                        col_d   = '0;
                        state_d = S_READ;
                    end
                end
                S_READ: begin
                    if (bus.rd_ready) begin
                        if (last_pix) begin
                            row_d   = '0;
                            col_d   = '0;
                            done_d  = 1'b1;
                            fcnt_d  = fcnt_q + FRAME_W'(1);
                            state_d = S_IDLE;
                            // Continuous mode re-latches durations so the next frame sees fresh values.
                            if (bus.continuous) begin
                                sh_erase_d   = bus.t_erase;
                                sh_expose_d  = bus.t_expose;
                                sh_convert_d = bus.t_convert;
                                cnt_d        = '0;
                                state_d      = S_ERASE;
                            end
                        end else if (col_q == COL_W'(COLS - 1)) begin
                            col_d = '0;
                            row_d = row_q + ROW_W'(1);
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            sh_erase_q   <= '0;
            sh_expose_q  <= '0;
            sh_convert_q <= '0;
            row_q        <= '0;
            col_q        <= '0;
            done_q       <= 1'b0;
            fcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sh_erase_q   <= sh_erase_d;
            sh_expose_q  <= sh_expose_d;
            sh_convert_q <= sh_convert_d;
            row_q        <= row_d;
            col_q        <= col_d;
            done_q       <= done_d;
            fcnt_q       <= fcnt_d;
        end
    end

    assign bus.erase      = (state_q == S_ERASE);
    assign bus.expose     = (state_q == S_EXPOSE);
    assign bus.convert    = (state_q == S_CONVERT);
    assign bus.read       = (state_q == S_READ);
    assign bus.rd_valid   = (state_q == S_READ);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.row_addr   = row_q;
    assign bus.col_addr   = col_q;
    assign bus.frame_done = done_q;
    assign bus.frame_cnt  = fcnt_q;
endmodule

// File: tb/tb_pixel_array_sequencer.sv
// Bench for pixel_array_sequencer (2x3 array, 2-bit frame counter): vector table, hand-written corner
// sequences and randomized single-shot frames checked against phase lengths and row-major pixel order.
module tb_pixel_array_sequencer;
    localparam int ROWS    = 2;
    localparam int COLS    = 3;
    localparam int CNT_W   = 16;
    localparam int FRAME_W = 2;
    localparam int NPIX    = ROWS * COLS;
    localparam int FMOD    = 1 << FRAME_W;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pixel_array_sequencer_if #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W), .FRAME_W(FRAME_W)) bus ();

    pixel_array_sequencer #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W), .FRAME_W(FRAME_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int te; int tx; int tc;
        int ee; int ex; int ec;
    } vec_t;
    vec_t vecs[5];

    int checks   = 0;
    int failures = 0;
    int exp_fcnt = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic int dmax1(input int t);
        return (t == 0) ? 1 : t;
    endfunction

    function automatic int addr_idx();
        return int'(bus.row_addr) * COLS + int'(bus.col_addr);
    endfunction

    function automatic int phase_sum();
        return int'(bus.erase) + int'(bus.expose) + int'(bus.convert) + int'(bus.read);
    endfunction

    task automatic start_frame(input int te, input int tx, input int tc, input bit cont);
        bus.t_erase    = CNT_W'(te);
        bus.t_expose   = CNT_W'(tx);
        bus.t_convert  = CNT_W'(tc);
        bus.continuous = cont;
        bus.start      = 1'b1;
        tick();
        bus.start      = 1'b0;
    endtask

    task automatic scramble();
        bus.start      = 1'($urandom_range(0, 1));
        bus.continuous = 1'($urandom_range(0, 1));
        bus.t_erase    = CNT_W'($urandom_range(0, 9));
        bus.t_expose   = CNT_W'($urandom_range(0, 9));
        bus.t_convert  = CNT_W'($urandom_range(0, 9));
    endtask

    // Starts at a sample where erase is expected high; ends at the frame_done sample.
    // stall_mode: 0 always ready, 1 random stalls, 2 two-cycle stall at pixel (0,2).
    task automatic measure_frame(input int exp_e, input int exp_x, input int exp_c,
                                 input int stall_mode, input int exp_rlen, input int exp_cnt,
                                 input bit exp_cont, input bit noise);
        int len, idx, stalls, held;
        bit rdy;
        len = 0;
        while (bus.erase && len < 1000) begin
            check("onehot_erase", phase_sum(), 1);
            if (noise) scramble();
            len++; tick();
        end
        check("erase_len", len, exp_e);
        len = 0;
        while (bus.expose && len < 1000) begin
            check("onehot_expose", phase_sum(), 1);
            if (noise) scramble();
            len++; tick();
        end
        check("expose_len", len, exp_x);
        len = 0;
        while (bus.convert && len < 1000) begin
            check("onehot_convert", phase_sum(), 1);
            if (noise) scramble();
            len++; tick();
        end
        check("convert_len", len, exp_c);
        if (noise) begin
            bus.start      = 1'b0;
            bus.continuous = 1'b0;
        end
        idx = 0; stalls = 0; held = 0; len = 0;
        while (bus.read && len < 1000) begin
            check("rd_valid", int'(bus.rd_valid), 1);
            check("addr_order", addr_idx(), idx);
            case (stall_mode)
                1:       rdy = ($urandom_range(0, 2) != 0);
                2:       rdy = !(idx == 2 && held < 2);
                default: rdy = 1'b1;
            endcase
            if (!rdy) begin
                stalls++;
                held++;
            end
            bus.rd_ready = rdy;
            if (rdy) idx++;
            len++; tick();
        end
        bus.rd_ready = 1'b1;
        check("pixels", idx, NPIX);
        check("read_len", len, (exp_rlen < 0) ? NPIX + stalls : exp_rlen);
        check("frame_done", int'(bus.frame_done), 1);
        check("frame_cnt", int'(bus.frame_cnt), exp_cnt);
        check("cont_erase", int'(bus.erase), int'(exp_cont));
        check("rd_valid_end", int'(bus.rd_valid), 0);
        check("addr_clear", addr_idx(), 0);
    endtask

    task automatic wait_addr(input int r, input int c, input string name);
        int n;
        n = 0;
        while (!(bus.read && int'(bus.row_addr) == r && int'(bus.col_addr) == c) && n < 200) begin
            tick(); n++;
        end
        check(name, int'(n < 200), 1);
    endtask

    initial begin
        int n, e, x, c;
        vecs[0] = '{3, 5, 4, 3, 5, 4};
        vecs[1] = '{1, 0, 1, 1, 1, 1};
        vecs[2] = '{0, 2, 0, 1, 2, 1};
        vecs[3] = '{2, 1, 3, 2, 1, 3};
        vecs[4] = '{4, 0, 0, 4, 1, 1};

        bus.start = 1'b0; bus.continuous = 1'b0; bus.rd_ready = 1'b1;
        bus.t_erase = '0; bus.t_expose = '0; bus.t_convert = '0;
`ifdef PIXSEQ_ABORT_EN
        bus.abort = 1'b0;
`endif
        reset_n = 1'b0;
        repeat (2) tick();
        check("rst_busy", int'(bus.busy), 0);
        check("rst_phases", phase_sum(), 0);
        check("rst_rd_valid", int'(bus.rd_valid), 0);
        check("rst_frame_done", int'(bus.frame_done), 0);
        check("rst_frame_cnt", int'(bus.frame_cnt), 0);
        check("rst_addr", addr_idx(), 0);
        reset_n = 1'b1;
        tick();
        check("idle_busy", int'(bus.busy), 0);

        // Table of durations; t_erase is disturbed after latch and must not matter.
        for (int i = 0; i < 5; i++) begin
            start_frame(vecs[i].te, vecs[i].tx, vecs[i].tc, 1'b0);
            bus.t_erase = CNT_W'(9);
            exp_fcnt = (exp_fcnt + 1) % FMOD;
            measure_frame(vecs[i].ee, vecs[i].ex, vecs[i].ec, 0, NPIX, exp_fcnt, 1'b0, 1'b0);
            check("end_busy", int'(bus.busy), 0);
            tick();
            check("done_pulse", int'(bus.frame_done), 0);
            check("idle_stays", int'(bus.busy), 0);
        end

        // Two-cycle stall at (0,2), then start accepted in the frame_done cycle.
        start_frame(3, 5, 4, 1'b0);
        exp_fcnt = (exp_fcnt + 1) % FMOD;
        measure_frame(3, 5, 4, 2, 8, exp_fcnt, 1'b0, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("b2b_done_low", int'(bus.frame_done), 0);
        exp_fcnt = (exp_fcnt + 1) % FMOD;
        measure_frame(3, 5, 4, 0, NPIX, exp_fcnt, 1'b0, 1'b0);

        // Continuous: three frames with re-latch, then two single shots to show the wrap.
        reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
        start_frame(2, 1, 1, 1'b1);
        bus.t_erase = CNT_W'(4);
        measure_frame(2, 1, 1, 0, NPIX, 1, 1'b1, 1'b0);
        measure_frame(4, 1, 1, 0, NPIX, 2, 1'b1, 1'b0);
        bus.continuous = 1'b0;
        measure_frame(4, 1, 1, 0, NPIX, 3, 1'b0, 1'b0);
        check("cont_end_idle", int'(bus.busy), 0);
        tick();
        start_frame(1, 1, 1, 1'b0);
        measure_frame(1, 1, 1, 0, NPIX, 0, 1'b0, 1'b0);
        tick();
        start_frame(1, 1, 1, 1'b0);
        measure_frame(1, 1, 1, 0, NPIX, 1, 1'b0, 1'b0);
        tick();

        // Asynchronous reset in the middle of READ.
        start_frame(1, 1, 1, 1'b0);
        wait_addr(1, 0, "reach_1_0");
        reset_n = 1'b0;
        #1;
        check("arst_read", int'(bus.read), 0);
        check("arst_rd_valid", int'(bus.rd_valid), 0);
        check("arst_busy", int'(bus.busy), 0);
        check("arst_frame_cnt", int'(bus.frame_cnt), 0);
        check("arst_addr", addr_idx(), 0);
        tick();
        reset_n = 1'b1;
        tick();
        start_frame(3, 5, 4, 1'b0);
        measure_frame(3, 5, 4, 0, NPIX, 1, 1'b0, 1'b0);
        exp_fcnt = 1;
        tick();

        // Random single-shot frames with stalls and input noise while busy.
        for (int i = 0; i < 20; i++) begin
            e = $urandom_range(0, 5);
            x = $urandom_range(0, 5);
            c = $urandom_range(0, 5);
            start_frame(e, x, c, 1'b0);
            exp_fcnt = (exp_fcnt + 1) % FMOD;
            measure_frame(dmax1(e), dmax1(x), dmax1(c), 1, -1, exp_fcnt, 1'b0, 1'b1);
            n = $urandom_range(1, 3);
            repeat (n) tick();
            check("rand_idle", int'(bus.busy), 0);
        end

`ifdef PIXSEQ_ABORT_EN
        start_frame(2, 3, 2, 1'b0);
        n = 0;
        while (!bus.expose && n < 50) begin tick(); n++; end
        check("reach_expose", int'(bus.expose), 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_expose", int'(bus.expose), 0);
        check("abort_done", int'(bus.frame_done), 0);
        check("abort_fcnt", int'(bus.frame_cnt), exp_fcnt);
        tick();
        check("abort_done2", int'(bus.frame_done), 0);

        start_frame(1, 1, 1, 1'b0);
        wait_addr(1, 2, "reach_last");
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_last_done", int'(bus.frame_done), 0);
        check("abort_last_fcnt", int'(bus.frame_cnt), exp_fcnt);
        check("abort_last_busy", int'(bus.busy), 0);
        check("abort_last_addr", addr_idx(), 0);

        bus.abort = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("abort_blocks_start", int'(bus.busy), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
